// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: register map, CTRL/STATUS
// bit positions, sequencer states and the period normalisation helper.
package pio_seq_pkg;

   // Config slave register addresses
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PERIOD   = 3'd1;
   localparam logic [2:0] REG_LENGTH   = 3'd2;
   localparam logic [2:0] REG_WR_INDEX = 3'd3;
   localparam logic [2:0] REG_PATTERN  = 3'd4;
   localparam logic [2:0] REG_STATUS   = 3'd5;
   localparam logic [2:0] REG_SOFT_OUT = 3'd6;

   // CTRL bit positions
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_LOOP   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bit positions
   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      WAIT = 2'd2
   } seq_state_e;

   // A programmed period of 0 behaves exactly like a period of 1.
   function automatic logic [31:0] period_eff(input logic [31:0] period);
      return (period == 32'd0) ? 32'd1 : period;
   endfunction

endpackage

// File: rtl/pio_seq_regfile.sv
// Config slave of the PIO pattern sequencer: write decode, CTRL/PERIOD/LENGTH/
// WR_INDEX registers, sticky done flag, pattern table and read-back mux.
module pio_seq_regfile
   import pio_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   // Avalon-MM config slave
   input  logic [2:0]       s_address,
   input  logic             s_chipselect,
   input  logic             s_write_n,
   input  logic [31:0]      s_writedata,
   output logic [31:0]      s_readdata,
   // Sequencer status and control from the FSM
   input  logic             busy,
   input  logic [IDX_W-1:0] cur_idx,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic             set_done,
   input  logic             clr_done,
   // Decoded write events
   output logic             ctrl_wr,
   output logic             ctrl_wr_enable,
   output logic             soft_wr,
   output logic [15:0]      soft_data,
   // Configuration to the FSM
   output logic             loop_en,
   output logic             irq_en,
   output logic             done,
   output logic [31:0]      period,
   output logic [IDX_W:0]   length,
   output logic [15:0]      rd_data
);

   localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

   logic             wr;
   logic             enable;
   logic [IDX_W-1:0] wr_index;
   logic [IDX_W:0]   len_field;
   logic [15:0]      pat_table [DEPTH];

   assign wr             = s_chipselect & ~s_write_n;
   assign ctrl_wr        = wr & (s_address == REG_CTRL);
   assign ctrl_wr_enable = s_writedata[CTRL_ENABLE];
   assign soft_wr        = wr & (s_address == REG_SOFT_OUT);
   assign soft_data      = s_writedata[15:0];
   assign len_field      = s_writedata[IDX_W:0];
   assign rd_data        = pat_table[rd_idx];

   // Config registers, sticky done flag and pattern table updates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable   <= 1'b0;
         loop_en  <= 1'b0;
         irq_en   <= 1'b0;
         period   <= '0;
         length   <= '0;
         wr_index <= '0;
         done     <= 1'b0;
         // NOTE: the table is cleared on reset because its contents are
         // architecturally visible; this keeps it in flops, not a RAM macro.
         for (int i = 0; i < DEPTH; i++) pat_table[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so the later "clear
         // enable" below cleanly overrides a CTRL write in the same cycle.
         if (ctrl_wr) begin
            enable  <= s_writedata[CTRL_ENABLE];
            loop_en <= s_writedata[CTRL_LOOP];
            irq_en  <= s_writedata[CTRL_IRQ_EN];
         end
         if (set_done) enable <= 1'b0;

         if (wr && s_address == REG_PERIOD) period <= s_writedata;
         if (wr && s_address == REG_LENGTH)
            length <= (len_field > LEN_MAX) ? LEN_MAX : len_field;

         if (wr && s_address == REG_WR_INDEX) begin
            wr_index <= s_writedata[IDX_W-1:0];
         end else if (wr && s_address == REG_PATTERN) begin
            pat_table[wr_index] <= s_writedata[15:0];
            wr_index            <= wr_index + IDX_W'(1);
         end

         // Setting done has priority over any clear in the same cycle
         if (set_done)
            done <= 1'b1;
         else if (clr_done || (wr && s_address == REG_STATUS && s_writedata[STATUS_DONE]))
            done <= 1'b0;
      end
   end

   // Combinational read-back mux; write-only and reserved addresses read 0
   always_comb begin
      // NOTE: default first so every path assigns s_readdata and no latch forms.
      s_readdata = '0;
      case (s_address)
         REG_CTRL:     s_readdata = {29'd0, irq_en, loop_en, enable};
         REG_PERIOD:   s_readdata = period;
         REG_LENGTH:   s_readdata = 32'(length);
         REG_WR_INDEX: s_readdata = 32'(wr_index);
         REG_STATUS:   s_readdata = {16'd0, 8'(cur_idx), 6'd0, done, busy};
         default:      s_readdata = '0;
      endcase
   end

endmodule

// File: rtl/pio_pattern_sequencer.sv
// Avalon-MM master that plays a CPU-loaded pattern table out to a 16-bit PIO,
// one entry every PERIOD clocks, once or looping, with a done interrupt.
module pio_pattern_sequencer
   import pio_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset_n,
   // Config slave
   input  logic [2:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   // Master towards PIO s1
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   output logic        irq
);

   seq_state_e       state, state_d;
   logic [IDX_W-1:0] idx, idx_d;
   logic [31:0]      cnt, cnt_d;
   logic             set_done, clr_done, cont;
   logic             ctrl_wr, ctrl_wr_enable, soft_wr, soft_fire;
   logic             start_req, stop_req, strobe_d;
   logic             loop_en, irq_en, done, busy;
   logic [15:0]      soft_data, rd_data;
   logic [31:0]      period, per_eff;
   logic [IDX_W:0]   length, last_idx;

   pio_seq_regfile #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
      .clk            (clk),
      .reset_n        (reset_n),
      .s_address      (s_address),
      .s_chipselect   (s_chipselect),
      .s_write_n      (s_write_n),
      .s_writedata    (s_writedata),
      .s_readdata     (s_readdata),
      .busy           (busy),
      .cur_idx        (idx),
      .rd_idx         (idx_d),
      .set_done       (set_done),
      .clr_done       (clr_done),
      .ctrl_wr        (ctrl_wr),
      .ctrl_wr_enable (ctrl_wr_enable),
      .soft_wr        (soft_wr),
      .soft_data      (soft_data),
      .loop_en        (loop_en),
      .irq_en         (irq_en),
      .done           (done),
      .period         (period),
      .length         (length),
      .rd_data        (rd_data)
   );

   assign start_req = ctrl_wr & ctrl_wr_enable;
   assign stop_req  = ctrl_wr & ~ctrl_wr_enable;
   assign per_eff   = period_eff(period);
   assign last_idx  = length - (IDX_W+1)'(1);
   assign busy      = (state != IDLE);
   assign soft_fire = soft_wr & (state == IDLE);
   assign strobe_d  = (state_d == EMIT) | soft_fire;
   assign irq       = done & irq_en;
   assign m_address = 2'b00;

   // Sequencer state, table index and period counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic: start/stop handling, index advance and period reload
   always_comb begin
      state_d  = state;
      idx_d    = idx;
      cnt_d    = cnt;
      set_done = 1'b0;
      clr_done = 1'b0;
      cont     = 1'b0;
      case (state)
         IDLE: begin
            if (start_req) begin
               if (length == '0) begin
                  set_done = 1'b1;
               end else begin
                  clr_done = 1'b1;
                  idx_d    = '0;
                  state_d  = EMIT;
               end
            end
         end
         EMIT: begin
            if (stop_req) begin
               state_d = IDLE;
            end else if ({1'b0, idx} != last_idx) begin
               idx_d = idx + IDX_W'(1);
               cont  = 1'b1;
            end else if (loop_en) begin
               idx_d = '0;
               cont  = 1'b1;
            end else begin
               state_d  = IDLE;
               set_done = 1'b1;
            end
            if (cont) begin
               if (per_eff == 32'd1) begin
                  state_d = EMIT;
               end else begin
                  state_d = WAIT;
                  cnt_d   = per_eff - 32'd2;
               end
            end
         end
         WAIT: begin
            if (stop_req)          state_d = IDLE;
            else if (cnt == '0)    state_d = EMIT;
            else                   cnt_d   = cnt - 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered master strobe: one cycle per EMIT entry or accepted SOFT_OUT
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
      end else begin
         m_chipselect <= strobe_d;
         m_write_n    <= ~strobe_d;
         if (state_d == EMIT)
            m_writedata <= {16'h0000, rd_data};
         else if (soft_fire)
            m_writedata <= {16'h0000, soft_data};
      end
   end

endmodule
